// File: rtl/unstriping_if.sv
// Lane/merged-word bus for the unstriping block: two qualified input lanes and
// the registered merged output with its sticky overflow flag.
interface unstriping_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] lane_0;
    logic             valid_0;
    logic [WIDTH-1:0] lane_1;
    logic             valid_1;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             overflow;

    modport master (
        output lane_0, valid_0, lane_1, valid_1,
        input  data_out, valid_out, overflow
    );

    modport slave (
        input  lane_0, valid_0, lane_1, valid_1,
        output data_out, valid_out, overflow
    );
endinterface

// File: rtl/unstriping.sv
// Re-merges two striped lanes through per-lane skew FIFOs and a strict
// round-robin selector. Optional dropped-word counter: UNSTRIPING_OVF_CNT_EN.
module unstriping #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic          clk_2f,
    input  logic          reset,
    unstriping_if.slave   bus
`ifdef UNSTRIPING_OVF_CNT_EN
    ,
    output logic [7:0]    ovf_count
`endif
);

    typedef enum logic {
        SEL_L0 = 1'b0,
        SEL_L1 = 1'b1
    } sel_e;

    localparam logic [PTR_W:0]   L_CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   L_CNT_ZERO = (PTR_W + 1)'(0);
    localparam logic [PTR_W:0]   L_CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] L_PTR_ZERO = PTR_W'(0);
    localparam logic [PTR_W-1:0] L_PTR_ONE  = PTR_W'(1);

    sel_e             r_state;
    sel_e             w_state_nxt;
    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] w_data_nxt;
    logic             r_valid_out;
    logic             w_valid_nxt;
    logic             r_overflow;

    logic [WIDTH-1:0] w_lane [2];
    logic [1:0]       w_valid;
    logic [WIDTH-1:0] r_mem [2][DEPTH];
    logic [PTR_W-1:0] r_wr_ptr [2];
    logic [PTR_W-1:0] r_rd_ptr [2];
    logic [PTR_W:0]   r_cnt [2];
    logic [1:0]       w_full;
    logic [1:0]       w_empty;
    logic [1:0]       w_pop;
    logic [1:0]       w_push;
    logic [1:0]       w_drop;

    assign w_lane[0] = bus.lane_0;
    assign w_lane[1] = bus.lane_1;
    assign w_valid   = {bus.valid_1, bus.valid_0};

    assign bus.data_out  = r_data_out;
    assign bus.valid_out = r_valid_out;
    assign bus.overflow  = r_overflow;

    // FIFO status flags
    always_comb begin
        w_full  = 2'b00;
        w_empty = 2'b00;
        for (int i = 0; i < 2; i++) begin
            w_full[i]  = (r_cnt[i] == L_CNT_FULL);
            w_empty[i] = (r_cnt[i] == L_CNT_ZERO);
        end
    end

    // Selector next-state: only the lane it points at may be popped; never skips
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = {WIDTH{1'b0}};
        w_valid_nxt = 1'b0;
        w_pop       = 2'b00;
        case (r_state)
            SEL_L0: begin
                if (!w_empty[0]) begin
                    w_pop[0]    = 1'b1;
                    w_data_nxt  = r_mem[0][r_rd_ptr[0]];
                    w_valid_nxt = 1'b1;
                    w_state_nxt = SEL_L1;
                end else begin
                    w_state_nxt = SEL_L0;
                end
            end
            SEL_L1: begin
                if (!w_empty[1]) begin
                    w_pop[1]    = 1'b1;
                    w_data_nxt  = r_mem[1][r_rd_ptr[1]];
                    w_valid_nxt = 1'b1;
                    w_state_nxt = SEL_L0;
                end else begin
                    w_state_nxt = SEL_L1;
                end
            end
            default: begin
                w_state_nxt = SEL_L0;
            end
        endcase
    end

    // Push accepted when room exists or the same edge frees a slot
    always_comb begin
        w_push = 2'b00;
        w_drop = 2'b00;
        for (int i = 0; i < 2; i++) begin
            w_push[i] = w_valid[i] && (!w_full[i] || w_pop[i]);
            w_drop[i] = w_valid[i] && w_full[i] && !w_pop[i];
        end
    end

    // Selector state, registered outputs and sticky overflow
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            r_state     <= SEL_L0;
            r_data_out  <= {WIDTH{1'b0}};
            r_valid_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_data_out  <= w_data_nxt;
            r_valid_out <= w_valid_nxt;
            r_overflow  <= r_overflow | (|w_drop);
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                r_wr_ptr[i] <= L_PTR_ZERO;
                r_rd_ptr[i] <= L_PTR_ZERO;
                r_cnt[i]    <= L_CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_push[i]) begin
                    r_wr_ptr[i] <= r_wr_ptr[i] + L_PTR_ONE;
                end
                if (w_pop[i]) begin
                    r_rd_ptr[i] <= r_rd_ptr[i] + L_PTR_ONE;
                end
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + L_CNT_ONE;
                    2'b01:   r_cnt[i] <= r_cnt[i] - L_CNT_ONE;
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
        end
    end

    // FIFO storage; stale entries are unreachable once the pointers reset
    always_ff @(posedge clk_2f) begin
        for (int i = 0; i < 2; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wr_ptr[i]] <= w_lane[i];
            end
        end
    end

`ifdef UNSTRIPING_OVF_CNT_EN
    logic [7:0] r_ovf_count;
    logic [7:0] w_drop_sum;

    assign w_drop_sum = {7'd0, w_drop[0]} + {7'd0, w_drop[1]};
    assign ovf_count  = r_ovf_count;

    // Saturating count of dropped words across both lanes
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            r_ovf_count <= 8'd0;
        end else if (r_ovf_count > (8'd255 - w_drop_sum)) begin
            r_ovf_count <= 8'd255;
        end else begin
            r_ovf_count <= r_ovf_count + w_drop_sum;
        end
    end
`endif

endmodule

// File: tb/tb_unstriping.sv
// Directed bench for unstriping: reset, ordering, skew, full-with-pop,
// overflow and mid-stream reset.
module tb_unstriping;

    logic clk_2f;
    logic reset;
    int   total;
    int   bad;

    unstriping_if #(.WIDTH(32)) bus ();

`ifdef UNSTRIPING_OVF_CNT_EN
    logic [7:0] ovf_count;
`endif

    unstriping #(.WIDTH(32), .DEPTH(4), .PTR_W(2)) u_dut (
        .clk_2f    (clk_2f),
        .reset     (reset),
        .bus       (bus)
`ifdef UNSTRIPING_OVF_CNT_EN
        ,
        .ovf_count (ovf_count)
`endif
    );

    initial begin
        clk_2f = 1'b0;
        forever #5 clk_2f = ~clk_2f;
    end

    task automatic tick();
        @(posedge clk_2f);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [31:0] l0,
                         input logic v1, input logic [31:0] l1);
        bus.valid_0 = v0;
        bus.lane_0  = l0;
        bus.valid_1 = v1;
        bus.lane_1  = l1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] d);
        chk({tag, ".valid"}, {31'd0, bus.valid_out}, {31'd0, v});
        chk({tag, ".data"}, bus.data_out, d);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        drive(1'b1, 32'hA5A5A5A5, 1'b1, 32'h5A5A5A5A);
        #1 reset = 1'b0;
        #1;
        chk_out("rst0", 1'b0, 32'h0);
        chk("rst0.ovf", {31'd0, bus.overflow}, 32'd0);
        tick();
        chk_out("rst1", 1'b0, 32'h0);
        tick();
        chk_out("rst2", 1'b0, 32'h0);
        chk("rst2.ovf", {31'd0, bus.overflow}, 32'd0);
        reset = 1'b1;

        // nominal ordering
        drive(1'b1, 32'hFFFFFFFF, 1'b0, 32'h0);
        tick(); chk_out("nom0", 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 32'hEEEEEEEE);
        tick(); chk_out("nom1", 1'b1, 32'hFFFFFFFF);
        drive(1'b1, 32'hDDDDDDDD, 1'b0, 32'h0);
        tick(); chk_out("nom2", 1'b1, 32'hEEEEEEEE);
        drive(1'b0, 32'h0, 1'b1, 32'hCCCCCCCC);
        tick(); chk_out("nom3", 1'b1, 32'hDDDDDDDD);
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        tick(); chk_out("nom4", 1'b1, 32'hCCCCCCCC);
        tick(); chk_out("nom5", 1'b0, 32'h0);

        // lane_1 three cycles behind lane_0
        drive(1'b1, 32'h00000003, 1'b0, 32'h0);
        tick(); chk_out("skw0", 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        tick(); chk_out("skw1", 1'b1, 32'h00000003);
        tick(); chk_out("skw2", 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 32'h00000004);
        tick(); chk_out("skw3", 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        tick(); chk_out("skw4", 1'b1, 32'h00000004);
        tick(); chk_out("skw5", 1'b0, 32'h0);
        chk("skw.ovf", {31'd0, bus.overflow}, 32'd0);

        // fill lane_0 while the selector waits on lane_1
        drive(1'b1, 32'h10, 1'b0, 32'h0);
        tick(); chk_out("fil1", 1'b0, 32'h0);
        drive(1'b1, 32'h11, 1'b0, 32'h0);
        tick(); chk_out("fil2", 1'b1, 32'h10);
        drive(1'b1, 32'h12, 1'b0, 32'h0);
        tick(); chk_out("fil3", 1'b0, 32'h0);
        drive(1'b1, 32'h13, 1'b0, 32'h0);
        tick(); chk_out("fil4", 1'b0, 32'h0);
        drive(1'b1, 32'h14, 1'b0, 32'h0);
        tick(); chk_out("fil5", 1'b0, 32'h0);
        chk("fil5.ovf", {31'd0, bus.overflow}, 32'd0);
        drive(1'b0, 32'h0, 1'b1, 32'hBBBBBBBB);
        tick(); chk_out("fil6", 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        tick(); chk_out("fil7", 1'b1, 32'hBBBBBBBB);

        // push into full lane_0 on its popping edge
        drive(1'b1, 32'hAAAAAAAA, 1'b0, 32'h0);
        tick(); chk_out("fpop", 1'b1, 32'h11);
        chk("fpop.ovf", {31'd0, bus.overflow}, 32'd0);

        // push into full lane_0 with no pop: dropped
        drive(1'b1, 32'h15, 1'b0, 32'h0);
        tick(); chk_out("ovf0", 1'b0, 32'h0);
        chk("ovf0.ovf", {31'd0, bus.overflow}, 32'd1);
`ifdef UNSTRIPING_OVF_CNT_EN
        chk("ovf0.cnt", {24'd0, ovf_count}, 32'd1);
`endif
        drive(1'b0, 32'h0, 1'b1, 32'hB1);
        tick(); chk_out("drn0", 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 32'hB2);
        tick(); chk_out("drn1", 1'b1, 32'hB1);
        drive(1'b0, 32'h0, 1'b1, 32'hB3);
        tick(); chk_out("drn2", 1'b1, 32'h12);
        drive(1'b0, 32'h0, 1'b1, 32'hB4);
        tick(); chk_out("drn3", 1'b1, 32'hB2);
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        tick(); chk_out("drn4", 1'b1, 32'h13);
        tick(); chk_out("drn5", 1'b1, 32'hB3);
        tick(); chk_out("drn6", 1'b1, 32'h14);
        tick(); chk_out("drn7", 1'b1, 32'hB4);
        tick(); chk_out("drn8", 1'b1, 32'hAAAAAAAA);
        tick(); chk_out("drn9", 1'b0, 32'h0);
        chk("drn9.ovf", {31'd0, bus.overflow}, 32'd1);

        // mid-stream reset after two output words (selector now at lane 1)
        drive(1'b1, 32'h21, 1'b1, 32'h20);
        tick(); chk_out("mid0", 1'b0, 32'h0);
        drive(1'b1, 32'h23, 1'b1, 32'h22);
        tick(); chk_out("mid1", 1'b1, 32'h20);
        drive(1'b1, 32'h25, 1'b1, 32'h24);
        tick(); chk_out("mid2", 1'b1, 32'h21);
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        #2 reset = 1'b0;
        #1;
        chk_out("mrst", 1'b0, 32'h0);
        chk("mrst.ovf", {31'd0, bus.overflow}, 32'd0);
        tick(); chk_out("mrst1", 1'b0, 32'h0);
        reset = 1'b1;
        tick(); chk_out("post0", 1'b0, 32'h0);
        tick(); chk_out("post1", 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 32'h55);
        tick(); chk_out("post2", 1'b0, 32'h0);
        drive(1'b1, 32'h66, 1'b0, 32'h0);
        tick(); chk_out("post3", 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        tick(); chk_out("post4", 1'b1, 32'h66);
        tick(); chk_out("post5", 1'b1, 32'h55);
        tick(); chk_out("post6", 1'b0, 32'h0);
`ifdef UNSTRIPING_OVF_CNT_EN
        chk("post6.cnt", {24'd0, ovf_count}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unstriping.md
Name: unstriping

Overview:
- Downstream counterpart of the striping stage; re-merges the two 32-bit lanes (lane_0, lane_1) into a single word stream on clk_2f.
- Each lane feeds a small per-lane FIFO that absorbs inter-lane skew.
- A two-state round-robin selector pops words strictly alternating lane 0, lane 1, so original word order is restored: word k comes from lane k mod 2.

Parameters:
- WIDTH, 32, data width of lanes and output.
- DEPTH, 4, entries per lane FIFO; power of 2, minimum 2.
- PTR_W, 2, pointer width, log2(DEPTH).

Ports:
- clk_2f  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- lane_0  input  WIDTH  lane 0 word.
- valid_0  input  1  lane_0 qualifier.
- lane_1  input  WIDTH  lane 1 word.
- valid_1  input  1  lane_1 qualifier.
- data_out  output  WIDTH  merged word, registered.
- valid_out  output  1  data_out qualifier, registered.
- overflow  output  1  sticky lane-FIFO overflow flag.

Behaviour:
- Reset (reset=0, asynchronous): data_out=0, valid_out=0, overflow=0. Both FIFOs empty (rd/wr pointers=0, counts=0). Selector = SEL_L0. Takes effect immediately, including mid-stream; all buffered words are discarded.
- Lane FIFO push:
  - A word is written when valid_i=1 and the FIFO is not full, or when it is full and the same edge pops that FIFO (simultaneous push+pop on full is accepted).
  - Per-lane count is 0..DEPTH; pointers wrap modulo DEPTH.
- No fall-through: a word written at edge N is poppable at edge N+1 at the earliest. Input-to-output latency is exactly 1 cycle (sampled at edge N, on data_out after edge N+1) when the selector already points at that lane.
- Selector FSM, states SEL_L0 and SEL_L1:
  - In SEL_Lx with FIFO x non-empty: pop head, data_out<=head, valid_out<=1, go to the other state.
  - In SEL_Lx with FIFO x empty: data_out<=0, valid_out<=0, stay in SEL_Lx. Never skip to the other lane, even if it holds data.
- Throughput: one word per clk_2f cycle when both lanes keep up. Matches striping's output rate of one word per lane every 2 cycles.
- Overflow:
  - valid_i=1 on a full FIFO with no same-edge pop: the word is dropped and overflow<=1.
  - overflow stays at 1 until reset. FIFO contents are unaffected.
- Both lanes valid on the same edge: both pushed independently, no conflict.
- Empty FIFO with push on the same edge: push accepted, nothing popped, valid_out=0 that cycle.
- Lane invalid data values are ignored; no writes occur when valid_i=0.

Optional Feature:
- Macro UNSTRIPING_OVF_CNT_EN.
- Defined:
  - Adds output port ovf_count (output, 8 bits).
  - Counts dropped words, summing both lanes; +2 when both lanes drop on the same edge.
  - Saturates at 255. Reset value 0; cleared only by reset.
- Not defined: port and counter absent; overflow flag behaviour unchanged.

Test Plan:
- Reset: hold reset=0 with valid_0=valid_1=1 -> data_out=0, valid_out=0, overflow=0 throughout. Release -> first merged word appears 1 cycle after the first lane_0 push.
- Nominal order:
  - Stimulus: lane_0 gets FFFFFFFF then DDDDDDDD, and lane_1 gets EEEEEEEE then CCCCCCCC, each lane valid every other cycle, lane_1 one cycle after lane_0.
  - Response: data_out = FFFFFFFF, EEEEEEEE, DDDDDDDD, CCCCCCCC on 4 consecutive cycles with valid_out=1, then valid_out=0 and data_out=0.
- Skew:
  - Stimulus: lane_1 delayed 3 cycles relative to lane_0 (words 00000003 on lane_0, 00000004 on lane_1).
  - Response: output stalls in SEL_L1 with valid_out=0 until lane_1 arrives, then 00000003, 00000004 in order; no overflow.
- Overflow:
  - Stimulus: push 5 words into lane_0 on consecutive cycles while lane_1 stays idle (DEPTH=4). Lane_0's head is popped at edge 2, so the FIFO reaches full at edge 5.
  - Response: word 6 pushed into the full lane_0 -> overflow=1 the next cycle and that word is absent from the output. With UNSTRIPING_OVF_CNT_EN, ovf_count=1.
- Full with simultaneous pop: lane_0 full, selector at SEL_L0, push AAAAAAAA on the popping edge -> accepted, overflow stays 0, AAAAAAAA emitted in order later.
- Mid-stream reset: assert reset=0 between the 2nd and 3rd output words -> outputs go to 0 asynchronously (before the next edge). After release, the old buffered words are never emitted and the selector restarts at lane 0.
